// File: rtl/board_run_ctrl.sv
// Board run controller: CPU reset hold, free-run/single-step clock enable, HALT latch and LED byte multiplexing.
// Optional step-button debouncer enabled by defining BOARD_RUN_CTRL_DEBOUNCE_EN.
module board_run_ctrl #(
  parameter int unsigned DIV         = 4,
  parameter int unsigned RST_HOLD    = 8,
  parameter int unsigned DISP_PERIOD = 16,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic        clk_undiv,
  input  logic        rst,
  input  logic        mode_step,
  input  logic        step_btn,
  input  logic        cpu_halt,
  input  logic [15:0] dbg_data,
  output logic        cpu_rst_n,
  output logic        cpu_ce,
  output logic [7:0]  led,
  output logic        halted
);

  localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int unsigned DW = $clog2(DIV);
  localparam int unsigned PW = (DISP_PERIOD > 1) ? $clog2(DISP_PERIOD) : 1;

  if (DIV < 2 || RST_HOLD < 1 || DISP_PERIOD < 1 || DB_CYCLES < 1) begin : g_bad_params
    $error("board_run_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_STEP_WAIT,
    S_STEP_FIRE,
    S_HALTED
  } state_t;

  state_t          r_state, w_nx_state;
  logic [HW-1:0]   r_hold_cnt, w_nx_hold_cnt;
  logic [DW-1:0]   r_div_cnt, w_nx_div_cnt;
  logic            r_cpu_ce, w_nx_cpu_ce;
  logic            r_cpu_rst_n;
  logic [PW-1:0]   r_disp_cnt;
  logic            r_disp_sel;
  logic [7:0]      r_led;
  logic            r_btn_s1, r_btn_s2, r_btn_prev;
  logic            w_btn_level;
  logic            w_step_pulse;

  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_btn_s1 <= step_btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

`ifdef BOARD_RUN_CTRL_DEBOUNCE_EN
  localparam int unsigned BW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  logic [BW-1:0] r_db_cnt;
  logic          r_db_level;

  // Level only follows the synchronizer after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (r_btn_s2 == r_db_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == BW'(DB_CYCLES - 1)) begin
      r_db_cnt   <= '0;
      r_db_level <= r_btn_s2;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end
  assign w_btn_level = r_db_level;
`else
  assign w_btn_level = r_btn_s2;
`endif

  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) r_btn_prev <= 1'b0;
    else      r_btn_prev <= w_btn_level;
  end

  assign w_step_pulse = w_btn_level & ~r_btn_prev;

  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= '0;
      r_div_cnt   <= '0;
      r_cpu_ce    <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_hold_cnt  <= w_nx_hold_cnt;
      r_div_cnt   <= w_nx_div_cnt;
      r_cpu_ce    <= w_nx_cpu_ce;
      r_cpu_rst_n <= (r_state != S_HOLD);
    end
  end

  // cpu_ce is registered, so each enable is decided one cycle ahead; a sampled halt cancels it.
  always_comb begin
    w_nx_state    = r_state;
    w_nx_hold_cnt = r_hold_cnt;
    w_nx_div_cnt  = r_div_cnt;
    w_nx_cpu_ce   = 1'b0;
    case (r_state)
      S_HOLD: begin
        w_nx_hold_cnt = r_hold_cnt + 1'b1;
        if (r_hold_cnt == HW'(RST_HOLD - 1)) begin
          w_nx_hold_cnt = '0;
          w_nx_div_cnt  = '0;
          w_nx_state    = mode_step ? S_STEP_WAIT : S_RUN;
        end
      end
      S_RUN: begin
        w_nx_div_cnt = (r_div_cnt == DW'(DIV - 1)) ? '0 : r_div_cnt + 1'b1;
        if (cpu_halt) begin
          w_nx_state = S_HALTED;
        end else begin
          w_nx_cpu_ce = (r_div_cnt == DW'(DIV - 1));
          if (mode_step) begin
            w_nx_state   = S_STEP_WAIT;
            w_nx_div_cnt = '0;
          end
        end
      end
      S_STEP_WAIT: begin
        if (cpu_halt) begin
          w_nx_state = S_HALTED;
        end else if (w_step_pulse) begin
          w_nx_state = S_STEP_FIRE;
        end else if (!mode_step) begin
          w_nx_state   = S_RUN;
          w_nx_div_cnt = '0;
        end
      end
      S_STEP_FIRE: begin
        if (cpu_halt) begin
          w_nx_state = S_HALTED;
        end else begin
          w_nx_cpu_ce = 1'b1;
          w_nx_state  = S_STEP_WAIT;
        end
      end
      S_HALTED: ;
      default: w_nx_state = S_HOLD;
    endcase
  end

  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) begin
      r_disp_cnt <= '0;
      r_disp_sel <= 1'b0;
      r_led      <= '0;
    end else begin
      if (r_disp_cnt == PW'(DISP_PERIOD - 1)) begin
        r_disp_cnt <= '0;
        r_disp_sel <= ~r_disp_sel;
      end else begin
        r_disp_cnt <= r_disp_cnt + 1'b1;
      end
      r_led <= r_disp_sel ? dbg_data[15:8] : dbg_data[7:0];
    end
  end

  assign cpu_rst_n = r_cpu_rst_n;
  assign cpu_ce    = r_cpu_ce;
  assign led       = r_led;
  assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_board_run_ctrl.sv
// Directed bench for board_run_ctrl: expected cpu_ce cycles are queued as stimulus is driven and
// compared every cycle, alongside LED multiplex and CPU reset models.
module tb_board_run_ctrl;

  localparam int DIV         = 4;
  localparam int RST_HOLD    = 8;
  localparam int DISP_PERIOD = 16;
  localparam int DB_CYCLES   = 4;
`ifdef BOARD_RUN_CTRL_DEBOUNCE_EN
  localparam int STEP_LAT = 3 + DB_CYCLES;
`else
  localparam int STEP_LAT = 3;
`endif

  logic        clk_undiv = 1'b0;
  logic        rst       = 1'b0;
  logic        mode_step = 1'b0;
  logic        step_btn  = 1'b0;
  logic        cpu_halt  = 1'b0;
  logic [15:0] dbg_data  = 16'hA55A;
  logic        cpu_rst_n;
  logic        cpu_ce;
  logic [7:0]  led;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int cyc    = -1;
  int ce_q[$];

  board_run_ctrl #(
    .DIV         (DIV),
    .RST_HOLD    (RST_HOLD),
    .DISP_PERIOD (DISP_PERIOD),
    .DB_CYCLES   (DB_CYCLES)
  ) dut (
    .clk_undiv (clk_undiv),
    .rst       (rst),
    .mode_step (mode_step),
    .step_btn  (step_btn),
    .cpu_halt  (cpu_halt),
    .dbg_data  (dbg_data),
    .cpu_rst_n (cpu_rst_n),
    .cpu_ce    (cpu_ce),
    .led       (led),
    .halted    (halted)
  );

  always #5 clk_undiv = ~clk_undiv;

  // Index of the most recent rising edge since reset release (first edge = 0).
  always @(posedge clk_undiv or negedge rst) begin
    if (!rst) cyc <= -1;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk_undiv);
      guard++;
    end
    check("wait_cyc", 32'(cyc), 32'(n));
  endtask

  task automatic release_rst();
    @(negedge clk_undiv);
    #2 rst = 1'b1;
  endtask

  always @(negedge clk_undiv) begin
    logic       exp_ce;
    logic [7:0] exp_led;
    if (rst && cyc >= 0) begin
      exp_ce = (ce_q.size() > 0) && (ce_q[0] == cyc);
      if (exp_ce) void'(ce_q.pop_front());
      check("cpu_ce", 32'(cpu_ce), 32'(exp_ce));
      exp_led = (((cyc / DISP_PERIOD) % 2) == 1) ? dbg_data[15:8] : dbg_data[7:0];
      check("led", 32'(led), 32'(exp_led));
      check("cpu_rst_n", 32'(cpu_rst_n), 32'(cyc >= RST_HOLD));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk_undiv);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_cpu_ce",    32'(cpu_ce),    32'd0);
    check("rst_led",       32'(led),       32'h00);
    check("rst_halted",    32'(halted),    32'd0);

    // Free-run: enables at 11, 15, 19, ... then halt just before the enable at 43
    for (int k = RST_HOLD + DIV - 1; k < 41; k += DIV) ce_q.push_back(k);
    release_rst();
    wait_cyc(RST_HOLD - 1);
    check("hold_low_last", 32'(cpu_rst_n), 32'd0);
    wait_cyc(RST_HOLD);
    check("hold_rise", 32'(cpu_rst_n), 32'd1);
    wait_cyc(42);
    check("pre_halt", 32'(halted), 32'd0);
    cpu_halt = 1'b1;
    wait_cyc(43);
    check("halted_set", 32'(halted), 32'd1);
    cpu_halt = 1'b0;
    wait_cyc(45);
    mode_step = 1'b1;
    step_btn  = 1'b1;
    wait_cyc(50);
    step_btn  = 1'b0;
    wait_cyc(55);
    mode_step = 1'b0;
    wait_cyc(70);
    check("halted_sticky", 32'(halted), 32'd1);
    check("q_drained_halt", 32'(ce_q.size()), 32'd0);

    // Reset while halted
    @(negedge clk_undiv);
    #2 rst = 1'b0;
    #1;
    check("rst2_halted", 32'(halted),    32'd0);
    check("rst2_rst_n",  32'(cpu_rst_n), 32'd0);

    // Reset asserted during a cpu_ce pulse
    ce_q.push_back(RST_HOLD + DIV - 1);
    release_rst();
    wait_cyc(RST_HOLD + DIV - 1);
    #2;
    check("ce_before_midrst", 32'(cpu_ce), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_ce",    32'(cpu_ce),    32'd0);
    check("midrst_rst_n", 32'(cpu_rst_n), 32'd0);
    check("midrst_led",   32'(led),       32'h00);
    check("q_drained_midrst", 32'(ce_q.size()), 32'd0);

    // Single-step: three 5-cycle presses, then a 2-cycle glitch
    mode_step = 1'b1;
    release_rst();
    wait_cyc(RST_HOLD - 1);
    check("hold2_low_last", 32'(cpu_rst_n), 32'd0);
    for (int p = 0; p < 3; p++) begin
      wait_cyc(10 + p * 15);
      step_btn = 1'b1;
      ce_q.push_back(10 + p * 15 + 1 + STEP_LAT);
      wait_cyc(15 + p * 15);
      step_btn = 1'b0;
    end
    wait_cyc(55);
    step_btn = 1'b1;
`ifndef BOARD_RUN_CTRL_DEBOUNCE_EN
    ce_q.push_back(56 + STEP_LAT);
`endif
    wait_cyc(57);
    step_btn = 1'b0;

    // Back to free-run: RUN entered at edge 66 with div_cnt cleared
    wait_cyc(65);
    mode_step = 1'b0;
    ce_q.push_back(70);
    ce_q.push_back(74);
    wait_cyc(76);
    mode_step = 1'b1;
    wait_cyc(80);
    step_btn = 1'b1;
    ce_q.push_back(81 + STEP_LAT);
    wait_cyc(85);
    step_btn = 1'b0;
    check("step_not_halted", 32'(halted), 32'd0);

    // Halt from single-step; later presses are dropped
    wait_cyc(92);
    cpu_halt = 1'b1;
    wait_cyc(93);
    check("halted_step", 32'(halted), 32'd1);
    cpu_halt = 1'b0;
    wait_cyc(95);
    step_btn = 1'b1;
    wait_cyc(100);
    step_btn = 1'b0;
    wait_cyc(115);
    check("halted_step_sticky", 32'(halted), 32'd1);
    check("q_drained_end", 32'(ce_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
